mpu_sequencer: RTL
==================

MPU_SEQUENCER -- requirements
Module: mpu_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DEV_ADDR, 7'h68, MPU-6050 7-bit I2C address.
- GYRO_FS, 2'b00, FS_SEL value written to register 0x1B bits [4:3].
- SAMPLE_PERIOD, 1000000, clock cycles between burst-read starts.
- RETRY_WAIT, 10000, backoff cycles after a NACK.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_in, in, 1, single clock.
- rst_n_in, in, 1, reset; asynchronous, active-low.
- en_in, in, 1, run enable.
- cmd_valid_out, out, 1, command to byte-level I2C engine valid.
- cmd_ready_in, in, 1, engine accepts command.
- cmd_op_out, out, 3, opcode: 0 START, 1 STOP, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 RESTART.
- cmd_data_out, out, 8, byte for WRITE; 0 otherwise.
- rsp_valid_in, in, 1, engine completed the outstanding command.
- rsp_data_in, in, 8, byte read (READ_* only).
- rsp_nack_in, in, 1, slave NACK (WRITE only).
- gx_out, gy_out, gz_out, out, 16 each, signed gyro samples.
- sample_valid_out, out, 1, one-cycle pulse when samples are updated.
- init_done_out, out, 1, configuration complete.
- err_count_out, out, 8, saturating NACK count.
- busy_out, out, 1, a transaction is in progress.

Function
REQ-003 A command transfers on the cycle where cmd_valid_out && cmd_ready_in; cmd_op_out and cmd_data_out SHALL hold stable while cmd_valid_out && !cmd_ready_in.
REQ-004 At most one command SHALL be outstanding: after a transfer, cmd_valid_out stays 0 until rsp_valid_in.
REQ-005 rsp_valid_in with no outstanding command SHALL be ignored.
REQ-006 State machine: IDLE, WAKE, CFG, WAIT, BURST, ABORT, BACKOFF. A step index within WAKE, CFG and BURST selects the current command.
REQ-007 WAKE SHALL issue: START, WRITE {DEV_ADDR,0}, WRITE 8'h6B, WRITE 8'h00, STOP.
REQ-008 CFG SHALL issue: START, WRITE {DEV_ADDR,0}, WRITE 8'h1B, WRITE {3'b0,GYRO_FS,3'b0}, STOP.
REQ-009 BURST SHALL issue: START, WRITE {DEV_ADDR,0}, WRITE 8'h43, RESTART, WRITE {DEV_ADDR,1}, READ_ACK x5, READ_NACK, STOP.
REQ-010 Transitions:
- IDLE->WAKE when en_in=1 and init_done_out=0.
- IDLE->WAIT when en_in=1 and init_done_out=1.
- WAKE->CFG on STOP response.
- CFG->WAIT on STOP response; init_done_out is set at that point.
- WAIT->BURST when the period counter reaches SAMPLE_PERIOD-1.
- BURST->WAIT on STOP response.
REQ-011 The period counter SHALL reset to 0 on each BURST entry and saturate at SAMPLE_PERIOD-1. If a burst outlasts the period, the next burst starts on the cycle after WAIT entry.
REQ-012 Read bytes b0..b5 SHALL be captured in order; gx={b0,b1}, gy={b2,b3}, gz={b4,b5} (big-endian).
REQ-013 All three sample outputs SHALL update together, with sample_valid_out=1 for one cycle, on the cycle after the burst STOP response.
REQ-014 A WRITE response with rsp_nack_in=1 SHALL:
- increment err_count_out, saturating at 255;
- enter ABORT, which issues STOP;
- enter BACKOFF for RETRY_WAIT cycles;
- restart the same transaction (WAKE, CFG or BURST) from step 0.
REQ-015 An aborted burst SHALL NOT update the sample outputs or pulse sample_valid_out.
REQ-016 rsp_nack_in on non-WRITE responses SHALL be ignored.
REQ-017 en_in falling mid-transaction: the current transaction (including ABORT/STOP) SHALL complete, then the block enters IDLE. From WAIT or BACKOFF it enters IDLE immediately. init_done_out is retained.
REQ-018 busy_out SHALL be 1 in WAKE, CFG, BURST and ABORT; 0 otherwise.

Reset
REQ-019 On rst_n_in=0, asynchronously:
- state=IDLE, all counters and the step index = 0;
- cmd_valid_out=0, cmd_op_out=0, cmd_data_out=0;
- gx/gy/gz=0, sample_valid_out=0, init_done_out=0, err_count_out=0, busy_out=0.
REQ-020 Reset mid-transaction SHALL abandon it without issuing STOP. After release with en_in=1, the block restarts at WAKE.

Verification
REQ-021 Bench-driven engine model: cmd_ready_in always 1, response 3 cycles after each transfer, en_in=1, SAMPLE_PERIOD=200, RETRY_WAIT=20. Directed scenarios:
- Init: WAKE then CFG command streams match REQ-007/008 exactly, including WRITE bytes 0xD0,0x6B,0x00 and 0xD0,0x1B,0x00; init_done_out rises after the second STOP.
- Burst: read bytes 12,34,FF,FE,00,80 -> gx=16'h1234, gy=16'hFFFE, gz=16'h0080, one sample_valid_out pulse; burst starts repeat every 200 cycles.
- NACK on the address WRITE of a burst -> STOP issued, err_count_out=1, 20-cycle gap, burst retried from START, no sample pulse for the aborted burst. Force 300 NACKs -> err_count_out=255.
- Backpressure: cmd_ready_in low 5 cycles per command -> op/data stable; command sequence unchanged.
- en_in dropped at burst step 4 -> burst completes and samples update, then IDLE, no further commands; en_in restored -> goes to WAIT, not WAKE.
- rst_n_in pulsed at burst step 7 -> all outputs at reset values immediately; after release, WAKE restarts with START.

Source files
------------

// File: rtl/mpu_sequencer.sv
// mpu_sequencer: MPU-6050 wake/config then periodic gyro burst-read command sequencer.
module mpu_sequencer #(
   parameter logic [6:0]  DEV_ADDR      = 7'h68,
   parameter logic [1:0]  GYRO_FS       = 2'b00,
   parameter int unsigned SAMPLE_PERIOD = 1000000,
   parameter int unsigned RETRY_WAIT    = 10000
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        en_in,
   output logic        cmd_valid_out,
   input  logic        cmd_ready_in,
   output logic [2:0]  cmd_op_out,
   output logic [7:0]  cmd_data_out,
   input  logic        rsp_valid_in,
   input  logic [7:0]  rsp_data_in,
   input  logic        rsp_nack_in,
   output logic [15:0] gx_out,
   output logic [15:0] gy_out,
   output logic [15:0] gz_out,
   output logic        sample_valid_out,
   output logic        init_done_out,
   output logic [7:0]  err_count_out,
   output logic        busy_out
);
   typedef enum logic [2:0] {IDLE, WAKE, CFG, WAIT, BURST, ABORT, BACKOFF} state_t;
   localparam logic [2:0]  OP_START = 3'd0, OP_STOP = 3'd1, OP_WRITE = 3'd2;
   localparam logic [2:0]  OP_RDA = 3'd3, OP_RDN = 3'd4, OP_RESTART = 3'd5;
   localparam logic [31:0] PMAX = SAMPLE_PERIOD - 1;
   localparam logic [31:0] BMAX = RETRY_WAIT - 1;
   state_t      state_q, state_d, ret_q, ret_d;
   logic [3:0]  step_q, step_d;
   logic        pend_q, pend_d, sv_q, sv_d, init_q, init_d;
   logic [31:0] per_q, per_d, bo_q, bo_d;
   logic [47:0] sh_q, sh_d;
   logic [15:0] gx_q, gx_d, gy_q, gy_d, gz_q, gz_d;
   logic [7:0]  err_q, err_d, data;
   logic [2:0]  op;
   logic        last, xfer, rsp;

   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         state_q <= IDLE;
         ret_q   <= IDLE;
         step_q  <= '0;
         pend_q  <= 1'b0;
         per_q   <= '0;
         bo_q    <= '0;
         sh_q    <= '0;
         gx_q    <= '0;
         gy_q    <= '0;
         gz_q    <= '0;
         sv_q    <= 1'b0;
         init_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         step_q  <= step_d;
         pend_q  <= pend_d;
         per_q   <= per_d;
         bo_q    <= bo_d;
         sh_q    <= sh_d;
         gx_q    <= gx_d;
         gy_q    <= gy_d;
         gz_q    <= gz_d;
         sv_q    <= sv_d;
         init_q  <= init_d;
         err_q   <= err_d;
      end

   always_comb begin
      op   = OP_START;
      data = 8'h00;
      last = 1'b0;
      case (state_q)
         WAKE, CFG: begin
            op   = step_q == 4'd0 ? OP_START : step_q == 4'd4 ? OP_STOP : OP_WRITE;
            data = step_q == 4'd1 ? {DEV_ADDR, 1'b0} :
                   step_q == 4'd2 ? (state_q == WAKE ? 8'h6B : 8'h1B) :
                   step_q == 4'd3 && state_q == CFG ? {3'b000, GYRO_FS, 3'b000} : 8'h00;
            last = step_q == 4'd4;
         end
         BURST: begin
            op   = step_q == 4'd0 ? OP_START : step_q <= 4'd2 || step_q == 4'd4 ? OP_WRITE :
                   step_q == 4'd3 ? OP_RESTART : step_q <= 4'd9 ? OP_RDA :
                   step_q == 4'd10 ? OP_RDN : OP_STOP;
            data = step_q == 4'd1 ? {DEV_ADDR, 1'b0} : step_q == 4'd2 ? 8'h43 :
                   step_q == 4'd4 ? {DEV_ADDR, 1'b1} : 8'h00;
            last = step_q == 4'd11;
         end
         ABORT: begin
            op   = OP_STOP;
            last = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy_out         = state_q inside {WAKE, CFG, BURST, ABORT};
   assign cmd_valid_out    = busy_out && !pend_q;
   assign cmd_op_out       = op;
   assign cmd_data_out     = data;
   assign xfer             = cmd_valid_out && cmd_ready_in;
   assign rsp              = rsp_valid_in && pend_q;
   assign gx_out           = gx_q;
   assign gy_out           = gy_q;
   assign gz_out           = gz_q;
   assign sample_valid_out = sv_q;
   assign init_done_out    = init_q;
   assign err_count_out    = err_q;

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      step_d  = step_q;
      pend_d  = xfer ? 1'b1 : pend_q;
      per_d   = per_q == PMAX ? per_q : per_q + 32'd1;
      bo_d    = bo_q;
      sh_d    = sh_q;
      gx_d    = gx_q;
      gy_d    = gy_q;
      gz_d    = gz_q;
      sv_d    = 1'b0;
      init_d  = init_q;
      err_d   = err_q;
      if (rsp) begin
         pend_d = 1'b0;
         step_d = step_q + 4'd1;
         if (op == OP_RDA || op == OP_RDN)
            sh_d = {sh_q[39:0], rsp_data_in};
         if (op == OP_WRITE && rsp_nack_in) begin
            err_d   = err_q == 8'hFF ? err_q : err_q + 8'd1;
            ret_d   = state_q;
            state_d = ABORT;
            step_d  = '0;
         end else if (last) begin
            step_d  = '0;
            bo_d    = '0;
            state_d = !en_in ? IDLE : state_q == WAKE ? CFG :
                      state_q == ABORT ? BACKOFF : WAIT;
            init_d  = init_q || state_q == CFG;
            if (state_q == BURST) begin
               gx_d = sh_q[47:32];
               gy_d = sh_q[31:16];
               gz_d = sh_q[15:0];
               sv_d = 1'b1;
            end
         end
      end
      case (state_q)
         IDLE: if (en_in) state_d = init_q ? WAIT : WAKE;
         WAIT:
            if (!en_in) state_d = IDLE;
            else if (per_q == PMAX) begin
               state_d = BURST;
               step_d  = '0;
               per_d   = '0;
            end
         BACKOFF:
            if (!en_in) state_d = IDLE;
            else if (bo_q == BMAX) begin
               state_d = ret_q;
               step_d  = '0;
               if (ret_q == BURST) per_d = '0;
            end else bo_d = bo_q + 32'd1;
         default: ;
      endcase
   end
endmodule
